mux_ctl_gen: RTL and testbench

- Clocked upstream stage for the two-input handshake mux.
- Accepts a synchronous valid/ready stream of select bits and buffers them in a small FIFO.
- Issues each select as a dual-rail, four-phase control token on ctl_a/ctl_b, completing against the mux's asynchronous actl_i acknowledge.
- Forms the boundary between the clocked sequencing logic and the clockless mux.

---
 rtl/mux_ctl_pkg.sv | 19 +
 rtl/sync_ff.sv | 21 ++
 rtl/mux_ctl_gen.sv | 130 +++++++++++++
 tb/tb_mux_ctl_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ctl_pkg.sv
// Shared types and constants for the clocked control-token generator
// that feeds the two-input handshake mux.
package mux_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Occupancy needs one bit more than the pointers so "full" is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Reset-to-zero flop chain used to bring the mux's asynchronous
// acknowledge into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chain <= '0;
    else      r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/mux_ctl_gen.sv
// Buffers select tokens and issues each one as a dual-rail, four-phase
// control token on ctl_a/ctl_b, completing against the mux's actl_i.
//
// state   | meaning
// IDLE    | rails low, waiting for a buffered select
// ASSERT  | one rail high, waiting for synchronized ack to rise
// RELEASE | rails low, waiting for synchronized ack to fall
module mux_ctl_gen
  import mux_ctl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_sel,
  output logic                     ctl_a,
  output logic                     ctl_b,
  input  logic                     actl_i,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         tok_cnt,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  state_t           r_state;

  logic w_ack_s;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (actl_i),
    .q   (w_ack_s)
  );

  assign s_ready = (r_level < LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = s_valid && s_ready;
  assign w_head  = r_mem[r_rd_ptr];
  // Gating on ack_s keeps a rail from rising while the mux still acknowledges.
  assign w_pop   = !w_empty && !w_ack_s && ((r_state == IDLE) || (r_state == RELEASE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_sel;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      ctl_a     <= 1'b0;
      ctl_b     <= 1'b0;
      tok_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ctl_a <= 1'b0;
          ctl_b <= 1'b0;
          if (w_ack_s) proto_err <= 1'b1;
          if (w_pop) begin
            ctl_a   <= (w_head == SEL_A);
            ctl_b   <= (w_head == SEL_B);
            r_state <= ASSERT;
          end
        end
        ASSERT: begin
          if (w_ack_s) begin
            ctl_a   <= 1'b0;
            ctl_b   <= 1'b0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          ctl_a <= 1'b0;
          ctl_b <= 1'b0;
          if (!w_ack_s) begin
            tok_cnt <= tok_cnt + CNT_W'(1);
            if (w_pop) begin
              ctl_a   <= (w_head == SEL_A);
              ctl_b   <= (w_head == SEL_B);
              r_state <= ASSERT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          ctl_a   <= 1'b0;
          ctl_b   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (r_state != IDLE) || !w_empty;
  assign level = r_level;

endmodule

// File: tb/tb_mux_ctl_gen.sv
// Scoreboard bench for mux_ctl_gen: accepted selects are queued, and a
// monitor pops and compares on every rising rail.
module tb_mux_ctl_gen;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             s_sel = 1'b0;
  logic             ctl_a;
  logic             ctl_b;
  logic             actl_i;
  logic             busy;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] tok_cnt;
  logic             proto_err;

  mux_ctl_gen #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sel     (s_sel),
    .ctl_a     (ctl_a),
    .ctl_b     (ctl_b),
    .actl_i    (actl_i),
    .busy      (busy),
    .level     (level),
    .tok_cnt   (tok_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  // Ideal mux: acknowledge follows the rail OR three cycles later, unless overridden.
  logic [2:0] dl;
  logic       man_en = 1'b0;
  logic       man_v  = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) dl <= 3'b000;
    else      dl <= {dl[1:0], ctl_a | ctl_b};
  end
  assign actl_i = man_en ? man_v : dl[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic pa = 1'b0;
  logic pb = 1'b0;
  always @(negedge clk) begin
    bit e;
    if (rst) begin
      chk("rails_exclusive", {31'd0, ctl_a & ctl_b}, 32'd0);
      if ((ctl_a && !pa) || (ctl_b && !pb)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_token", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("token_rail", {30'd0, ctl_b, ctl_a}, e ? 32'd2 : 32'd1);
          chk("rtz_before_rise", {30'd0, pb, pa}, 32'd0);
        end
      end
    end
    pa = ctl_a;
    pb = ctl_b;
  end

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input bit sel);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_ready_timeout", 32'd0, 32'd1);
    s_valid = 1'b1;
    s_sel   = sel;
    exp_q.push_back(sel);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || actl_i) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seq[5];
    logic [CNT_W-1:0] base;
    int n;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    do_reset();
    chk("rst_ctl_a", {31'd0, ctl_a}, 0);
    chk("rst_ctl_b", {31'd0, ctl_b}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_tok_cnt", {24'd0, tok_cnt}, 0);
    chk("rst_proto_err", {31'd0, proto_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 1);

    // Single sel=0 token: write edge, then pop/assert edge
    s_valid = 1'b1;
    s_sel   = 1'b0;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("lat_after_write_a", {31'd0, ctl_a}, 0);
    chk("lat_after_write_level", {29'd0, level}, 1);
    @(posedge clk);
    #1;
    chk("lat_assert_a", {31'd0, ctl_a}, 1);
    chk("lat_assert_b", {31'd0, ctl_b}, 0);
    chk("lat_assert_level", {29'd0, level}, 0);
    wait_idle();
    chk("single_tok_cnt", {24'd0, tok_cnt}, 1);
    chk("single_proto_err", {31'd0, proto_err}, 0);

    // Five back-to-back tokens with the ack held low: FIFO fills behind the first
    man_en = 1'b1;
    man_v  = 1'b0;
    base   = tok_cnt;
    @(negedge clk);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_ready", {31'd0, s_ready}, 1);
      s_sel = seq[i];
      exp_q.push_back(seq[i]);
      @(posedge clk);
      @(negedge clk);
    end
    chk("full_level", {29'd0, level}, 4);
    chk("full_s_ready", {31'd0, s_ready}, 0);
    s_sel = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("full_refuse_level", {29'd0, level}, 4);
    chk("hold_ctl_b", {31'd0, ctl_b}, 1);
    chk("hold_busy", {31'd0, busy}, 1);
    chk("hold_tok_cnt", {24'd0, tok_cnt}, {24'd0, base});

    // actl_i rise to rail fall takes SYNC+1 edges
    man_v = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ack_lat_still_high", {31'd0, ctl_b}, 1);
    @(posedge clk);
    #1;
    chk("ack_lat_fall", {31'd0, ctl_b}, 0);
    man_en = 1'b0;
    man_v  = 1'b0;
    wait_idle();
    chk("b2b_tok_cnt", {24'd0, tok_cnt}, {24'd0, base + CNT_W'(5)});
    chk("b2b_level", {29'd0, level}, 0);

    // Asynchronous reset in the middle of ASSERT
    man_en = 1'b1;
    man_v  = 1'b0;
    push(1'b0);
    n = 0;
    while (!ctl_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_asserted", {31'd0, ctl_a}, 1);
    push(1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ctl_a", {31'd0, ctl_a}, 0);
    chk("midrst_ctl_b", {31'd0, ctl_b}, 0);
    chk("midrst_level", {29'd0, level}, 0);
    chk("midrst_tok_cnt", {24'd0, tok_cnt}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    man_en = 1'b0;
    push(1'b0);
    wait_idle();
    chk("post_rst_tok_cnt", {24'd0, tok_cnt}, 1);

    // Ack pulse while idle with nothing queued
    man_en = 1'b1;
    @(negedge clk);
    man_v = 1'b1;
    repeat (3) @(negedge clk);
    man_v = 1'b0;
    repeat (4) @(negedge clk);
    chk("proto_err_set", {31'd0, proto_err}, 1);
    chk("proto_rails", {30'd0, ctl_b, ctl_a}, 0);
    repeat (10) @(negedge clk);
    chk("proto_err_sticky", {31'd0, proto_err}, 1);
    chk("proto_tok_cnt", {24'd0, tok_cnt}, 1);
    do_reset();
    chk("proto_err_cleared", {31'd0, proto_err}, 0);
    man_en = 1'b0;

    // Counter wrap
    for (int i = 0; i < (1 << CNT_W) - 1; i++) push(i[0]);
    wait_idle();
    chk("wrap_pre", {24'd0, tok_cnt}, (1 << CNT_W) - 1);
    push(1'b1);
    wait_idle();
    chk("wrap_zero", {24'd0, tok_cnt}, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
